// File: rtl/edge_event_reader.sv
// edge_event_reader
//   Captures falling edges on a 32-bit monitored vector into a pending set.
//   Presents them one at a time through a valid/ready output stage, lowest
//   index first.
//
// Ports
//   clk        sole clock; all state updates happen on its rising edge
//   reset      synchronous active-low reset (0 = reset asserted)
//   din        monitored vector; any 1->0 transition on a bit is an event
//   evt_ready  consumer accepts the presented event when high with evt_valid
//   evt_valid  registered; an event index is being presented on evt_id
//   evt_id     registered; index of the presented falling edge
//   pending    registered; captured events not yet loaded into the output stage
//   ovf        registered; sticky event-lost flag
//
// Configuration
//   EDGE_EVENT_OVERFLOW_EN  when defined, ovf is set when an event arrives on
//                           a bit that is still pending and is not being
//                           loaded in that cycle. When undefined, ovf is tied
//                           to 0 and no detection logic exists.
module edge_event_reader (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] din,
  input  logic        evt_ready,
  output logic        evt_valid,
  output logic [4:0]  evt_id,
  output logic [31:0] pending,
  output logic        ovf
);

  logic [31:0] prev_din;
  logic [31:0] fall;
  logic        load;
  logic        have_pending;
  logic [4:0]  sel_id;
  logic [31:0] clr_mask;

  assign fall         = prev_din & ~din;
  assign load         = ~evt_valid | evt_ready;
  assign have_pending = |pending;

  // Lowest set index of the registered pending vector. A fall in the same
  // cycle is deliberately not visible here.
  always_comb begin
    sel_id = 5'd0;
    for (int i = 31; i >= 0; i--) begin
      if (pending[i]) sel_id = 5'(i);
    end
  end

  always_comb begin
    clr_mask = 32'd0;
    if (load && have_pending) clr_mask[sel_id] = 1'b1;
  end

  // prev_din keeps tracking din during reset so that the first capturable
  // fall after reset compares against a value sampled during reset.
  always_ff @(posedge clk) begin
    prev_din <= din;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pending   <= 32'd0;
      evt_valid <= 1'b0;
      evt_id    <= 5'd0;
    end else begin
      // Set wins over load-clear on the same bit.
      pending <= (pending & ~clr_mask) | fall;
      if (load) begin
        if (have_pending) begin
          evt_valid <= 1'b1;
          evt_id    <= sel_id;
        end else begin
          evt_valid <= 1'b0;
        end
      end
    end
  end

`ifdef EDGE_EVENT_OVERFLOW_EN
  // An event is lost when a bit falls again while its earlier event is still
  // pending and is not leaving the pending set this cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ovf <= 1'b0;
    end else if (|(fall & pending & ~clr_mask)) begin
      ovf <= 1'b1;
    end
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_edge_event_reader.sv
module tb_edge_event_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] din;
  logic        evt_ready;
  logic        evt_valid;
  logic [4:0]  evt_id;
  logic [31:0] pending;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  // Delivered-event histogram, counted from observed handshakes.
  int delivered [32];

  // Behavioural reference state.
  logic [31:0] m_prev;
  logic [31:0] m_pend;
  logic        m_valid;
  logic [4:0]  m_id;
  logic        m_ovf;

  edge_event_reader dut (
    .clk       (clk),
    .reset     (reset),
    .din       (din),
    .evt_ready (evt_ready),
    .evt_valid (evt_valid),
    .evt_id    (evt_id),
    .pending   (pending),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

`ifdef EDGE_EVENT_OVERFLOW_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  typedef struct {
    logic        rst;
    logic [31:0] d;
    logic        rdy;
    logic        e_valid;
    logic [4:0]  e_id;
    logic [31:0] e_pend;
    logic        e_ovf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: events are a set of indices; the consumer side takes the
  // smallest one whenever the presented slot is free or being accepted.
  function automatic int first_index(input logic [31:0] s);
    for (int i = 0; i < 32; i++) if (s[i]) return i;
    return -1;
  endfunction

  task automatic model_edge(input logic r, input logic [31:0] d, input logic rdy);
    logic [31:0] new_events;
    logic [31:0] leaving;
    int          k;
    if (!r) begin
      m_pend = '0; m_valid = 1'b0; m_id = '0; m_ovf = 1'b0;
    end else begin
      new_events = '0;
      for (int i = 0; i < 32; i++) new_events[i] = m_prev[i] && !d[i];
      leaving = '0;
      if (!m_valid || rdy) begin
        k = first_index(m_pend);
        if (k >= 0) begin
          m_valid = 1'b1; m_id = 5'(k); leaving[k] = 1'b1;
        end else begin
          m_valid = 1'b0;
        end
      end
      for (int i = 0; i < 32; i++)
        if (OVF_EN && new_events[i] && m_pend[i] && !leaving[i]) m_ovf = 1'b1;
      m_pend = (m_pend & ~leaving) | new_events;
    end
    m_prev = d;
  endtask

  task automatic step(input logic r, input logic [31:0] d, input logic rdy);
    reset = r; din = d; evt_ready = rdy;
    if (r && evt_valid === 1'b1 && rdy) delivered[evt_id]++;
    model_edge(r, d, rdy);
    @(posedge clk);
    #1;
    chk("valid",   {31'd0, evt_valid}, {31'd0, m_valid});
    chk("id",      {27'd0, evt_id},    {27'd0, m_id});
    chk("pending", pending,            m_pend);
    chk("ovf",     {31'd0, ovf},       {31'd0, m_ovf});
  endtask

  task automatic clear_hist();
    for (int i = 0; i < 32; i++) delivered[i] = 0;
  endtask

  vec_t vecs [13];

  initial begin
    reset = 1'b0; din = '0; evt_ready = 1'b0;
    m_prev = '0; m_pend = '0; m_valid = 1'b0; m_id = '0; m_ovf = 1'b0;
    clear_hist();

    // Single fall on bit 1, then three-bit burst with a stalled consumer.
    vecs[0]  = '{1'b0, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0};
    vecs[1]  = '{1'b1, 32'h2, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0};
    vecs[2]  = '{1'b1, 32'h0, 1'b1, 1'b0, 5'd0, 32'h2, 1'b0};
    vecs[3]  = '{1'b1, 32'h0, 1'b1, 1'b1, 5'd1, 32'h0, 1'b0};
    vecs[4]  = '{1'b1, 32'h0, 1'b1, 1'b0, 5'd1, 32'h0, 1'b0};
    vecs[5]  = '{1'b1, 32'hE, 1'b0, 1'b0, 5'd1, 32'h0, 1'b0};
    vecs[6]  = '{1'b1, 32'h0, 1'b0, 1'b0, 5'd1, 32'hE, 1'b0};
    vecs[7]  = '{1'b1, 32'h0, 1'b0, 1'b1, 5'd1, 32'hC, 1'b0};
    vecs[8]  = '{1'b1, 32'h0, 1'b0, 1'b1, 5'd1, 32'hC, 1'b0};
    vecs[9]  = '{1'b1, 32'h0, 1'b0, 1'b1, 5'd1, 32'hC, 1'b0};
    vecs[10] = '{1'b1, 32'h0, 1'b1, 1'b1, 5'd2, 32'h8, 1'b0};
    vecs[11] = '{1'b1, 32'h0, 1'b1, 1'b1, 5'd3, 32'h0, 1'b0};
    vecs[12] = '{1'b1, 32'h0, 1'b1, 1'b0, 5'd3, 32'h0, 1'b0};

    @(negedge clk);
    for (int i = 0; i < 13; i++) begin
      step(vecs[i].rst, vecs[i].d, vecs[i].rdy);
      chk($sformatf("tbl%0d.valid", i), {31'd0, evt_valid}, {31'd0, vecs[i].e_valid});
      chk($sformatf("tbl%0d.id", i),    {27'd0, evt_id},    {27'd0, vecs[i].e_id});
      chk($sformatf("tbl%0d.pend", i),  pending,            vecs[i].e_pend);
      chk($sformatf("tbl%0d.ovf", i),   {31'd0, ovf},       {31'd0, vecs[i].e_ovf});
    end

    // Re-fall on bit 0 while its earlier event is stuck behind a held bit 3.
    step(1'b0, 32'h0, 1'b0);
    clear_hist();
    step(1'b1, 32'h8, 1'b0);
    step(1'b1, 32'h0, 1'b0);
    step(1'b1, 32'h0, 1'b0);
    step(1'b1, 32'h1, 1'b0);
    step(1'b1, 32'h0, 1'b0);
    step(1'b1, 32'h1, 1'b0);
    step(1'b1, 32'h0, 1'b0);
    chk("refall.pend0", {31'd0, pending[0]}, 32'd1);
    step(1'b1, 32'h0, 1'b0);
    chk("refall.ovf", {31'd0, ovf}, {31'd0, OVF_EN});
    for (int i = 0; i < 5; i++) step(1'b1, 32'h0, 1'b1);
    chk("refall.bit0_count", delivered[0], 1);
    chk("refall.bit3_count", delivered[3], 1);

    // Bit 4 falls again while evt_id==4 is held un-accepted.
    step(1'b0, 32'h0, 1'b0);
    clear_hist();
    step(1'b1, 32'h10, 1'b0);
    step(1'b1, 32'h0, 1'b0);
    step(1'b1, 32'h0, 1'b0);
    chk("held4.id", {27'd0, evt_id}, 32'd4);
    step(1'b1, 32'h10, 1'b0);
    step(1'b1, 32'h0, 1'b0);
    chk("held4.pend", pending, 32'h10);
    for (int i = 0; i < 4; i++) step(1'b1, 32'h0, 1'b1);
    chk("held4.count", delivered[4], 2);
    chk("held4.ovf", {31'd0, ovf}, 32'd0);

    // Reset in the middle of a transfer, with a fall on bit 5 in the reset cycle.
    step(1'b0, 32'h0, 1'b0);
    step(1'b1, 32'h31, 1'b0);
    step(1'b1, 32'h0, 1'b0);
    step(1'b1, 32'h0, 1'b0);
    chk("rstmid.pend", pending, 32'h30);
    chk("rstmid.valid", {31'd0, evt_valid}, 32'd1);
    step(1'b1, 32'h20, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    clear_hist();
    chk("rstmid.after_pend", pending, 32'h0);
    chk("rstmid.after_valid", {31'd0, evt_valid}, 32'd0);
    chk("rstmid.after_id", {27'd0, evt_id}, 32'd0);
    for (int i = 0; i < 4; i++) step(1'b1, 32'h0, 1'b1);
    chk("rstmid.bit5_count", delivered[5], 0);
    chk("rstmid.quiet", {31'd0, evt_valid}, 32'd0);

    // Random traffic with sparse toggles and occasional reset.
    begin
      logic [31:0] d;
      d = $urandom();
      for (int c = 0; c < 200; c++) begin
        d = d ^ ($urandom() & $urandom() & $urandom());
        step(($urandom_range(15) != 0), d, 1'($urandom_range(1)));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/edge_event_reader.md
EDGE_EVENT_READER -- requirements
Module: edge_event_reader

Interface
REQ-001 SHALL have no parameters; data width fixed at 32 bits, event index 5 bits.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset (0 = reset asserted), sampled on rising clk.
REQ-004 din  input  32  monitored signal vector; a 1->0 transition on any bit is an event.
REQ-005 evt_ready  input  1  consumer accepts the presented event when high with evt_valid.
REQ-006 evt_valid  output  1  registered; an event index is presented on evt_id.
REQ-007 evt_id  output  5  registered; index of the bit whose falling edge is presented.
REQ-008 pending  output  32  registered; captured events not yet loaded into the output stage.
REQ-009 ovf  output  1  registered; sticky event-lost flag (see Configuration).

Function
REQ-010 SHALL register din into prev_din every cycle, including while reset is asserted.
REQ-011 Edge detect SHALL be fall[i] = prev_din[i] & ~din[i]; a 0->1 transition or a stable level is not an event.
REQ-012 pending[i] SHALL set on the cycle after fall[i]; it SHALL stay set until loaded into the output stage.
REQ-013 Output stage SHALL load when evt_valid==0 or (evt_valid & evt_ready); otherwise it SHALL hold evt_valid and evt_id unchanged.
REQ-014 On load with pending != 0: evt_id <= lowest set index of pending; evt_valid <= 1; that pending bit cleared.
REQ-015 On load with pending == 0: evt_valid <= 0; evt_id holds its previous value.
REQ-016 Selection SHALL use the registered pending vector only; a same-cycle fall is not visible to the load.
REQ-017 Latency: din[i] falls at sample edge N -> pending[i]=1 after N+1 -> evt_valid=1, evt_id=i after N+2 (output stage idle).
REQ-018 Simultaneous fall[i] and load-clear of bit i: set SHALL win; pending[i]=1 next cycle.
REQ-019 fall[i] while evt_id==i is held un-accepted: pending[i] SHALL set; both events are delivered.
REQ-020 Multiple simultaneous falls SHALL all be captured; delivery order is ascending index, one per accepted transfer.
REQ-021 Throughput: one event per cycle while evt_ready is held high and pending != 0.
REQ-022 evt_ready while evt_valid==0 SHALL have no effect.

Reset
REQ-023 While reset==0: pending=0, evt_valid=0, evt_id=0, ovf=0; prev_din still loads din.
REQ-024 Reset mid-transfer SHALL drop the presented event and all pending events without reporting them.
REQ-025 A fall occurring in the cycle reset is asserted SHALL be discarded; the first capturable fall compares against din sampled during reset.

Configuration
REQ-026 Macro EDGE_EVENT_OVERFLOW_EN SHALL control event-loss detection.
REQ-027 Defined: ovf <= 1 when fall[i] occurs while pending[i]==1 and bit i is not being load-cleared that cycle; ovf clears only on reset.
REQ-028 Undefined: ovf SHALL be constant 0 with no detection logic; all other behaviour is identical.

Verification
REQ-029 Reset, din=0x2, then din=0x0, evt_ready=1 -> pending=0x2 one cycle later; evt_valid=1, evt_id=1 the next cycle; then evt_valid=0.
REQ-030 din 0xE->0x0, evt_ready=0 for 3 cycles, then 1 -> evt_id=1 held stable while stalled; then evt_id 2 and 3 on consecutive cycles; pending ends at 0.
REQ-031 din 0x1->0x0->0x1->0x0 with evt_ready=0 -> second fall on bit 0 while pending[0]=1 gives ovf=1 with macro, ovf=0 without; exactly one bit-0 event is delivered.
REQ-032 evt_id=4 held un-accepted; din[4] falls again -> pending[4]=1; two bit-4 events are delivered after evt_ready=1; ovf stays 0.
REQ-033 pending=0x30, evt_valid=1; assert reset for one cycle with din=0x20->0x00 -> all outputs 0 after reset; no event reported for bit 5.
REQ-034 200 random cycles of din/evt_ready with reset asserted at about 1/16 probability -> compare cycle-by-cycle against a behavioural model of REQ-010..REQ-028.
